// File: rtl/bootrom_pkg.sv
// Shared types and helpers for the bootrom controller.
//   bootrom_ctrl_state_e : sequencer states
//   req_size_e           : data access size (32-bit / 64-bit)
//   owner_e              : which requester owns the in-flight access
//   addr_fault()         : range / alignment check of a byte address
//   lane32()             : little-endian 32-bit lane select from a ROM word
package bootrom_pkg;

   localparam int ROM_DATA_WIDTH = 64;

   typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} bootrom_ctrl_state_e;
   typedef enum logic {SZ_W = 1'b0, SZ_D = 1'b1} req_size_e;
   typedef enum logic {OWN_I = 1'b0, OWN_D = 1'b1} owner_e;

   // The top word index (2^aw - 1) is reserved, so it counts as out of range.
   function automatic logic addr_fault(input logic [31:0] addr,
                                       input logic        is_data,
                                       input logic        size_d,
                                       input int unsigned aw);
      logic [28:0] lim;
      logic        oor;
      logic        mis;
      lim = 29'((64'd1 << aw) - 64'd1);
      oor = (addr[31:3] >= lim);
      if (is_data && size_d) mis = (addr[2:0] != 3'b000);
      else                   mis = (addr[1:0] != 2'b00);
      return oor | mis;
   endfunction

   function automatic logic [31:0] lane32(input logic [ROM_DATA_WIDTH-1:0] w,
                                          input logic hi);
      return hi ? w[63:32] : w[31:0];
   endfunction

endpackage

// File: rtl/bootrom_ctrl_rr_arb2.sv
// Two-way round-robin arbiter (combinational).
//   valid_i  : request valids, bit0 = fetch, bit1 = data
//   last_i   : port served last (1 = data)
//   accept_i : a grant is taken this cycle (pointer may advance)
//   gnt_o    : one-hot grant
//   last_d_o : next value of the last-served pointer
module rr_arb2 (
   input  logic [1:0] valid_i,
   input  logic       last_i,
   input  logic       accept_i,
   output logic [1:0] gnt_o,
   output logic       last_d_o
);

   always_comb begin
      gnt_o = valid_i;
      // On a tie the port that was not served last wins.
      if (&valid_i) gnt_o = last_i ? 2'b01 : 2'b10;
      last_d_o = last_i;
      if (accept_i && (|gnt_o)) last_d_o = gnt_o[1];
   end

endmodule

// File: rtl/bootrom_ctrl.sv
// Bootrom sequencer shared by instruction fetch and data load ports.
// One ROM access in flight at a time; faults answer without touching the ROM.
//   clk, rst_n                  : clock, synchronous active-low reset
//   i_req_* / i_rsp_*           : fetch request / response (32-bit data)
//   d_req_* / d_rsp_*           : data request / response (64-bit data)
//   rom_addr                    : registered word index to the bootrom
//   rom_rdata                   : bootrom data, one cycle after rom_addr sampled
module bootrom_ctrl
   import bootrom_pkg::*;
#(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 64
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_req_valid,
   output logic                  i_req_ready,
   input  logic [31:0]           i_req_addr,
   output logic                  i_rsp_valid,
   input  logic                  i_rsp_ready,
   output logic [31:0]           i_rsp_data,
   output logic                  i_rsp_err,
   input  logic                  d_req_valid,
   output logic                  d_req_ready,
   input  logic [31:0]           d_req_addr,
   input  logic                  d_req_size,
   output logic                  d_rsp_valid,
   input  logic                  d_rsp_ready,
   output logic [63:0]           d_rsp_data,
   output logic                  d_rsp_err,
   output logic [ADDR_WIDTH-1:0] rom_addr,
   input  logic [DATA_WIDTH-1:0] rom_rdata
);

   if (DATA_WIDTH != ROM_DATA_WIDTH) begin : g_bad_width
      $fatal(1, "bootrom_ctrl: DATA_WIDTH must be 64");
   end

   bootrom_ctrl_state_e   state_q;
   owner_e                own_q;
   req_size_e             size_q;
   logic                  lane_hi_q;
   logic                  last_q, last_d;
   logic [ADDR_WIDTH-1:0] rom_addr_q;
   logic                  i_rsp_valid_q, d_rsp_valid_q;
   logic [31:0]           i_rsp_data_q;
   logic [63:0]           d_rsp_data_q;
   logic                  i_rsp_err_q, d_rsp_err_q;

   logic [1:0]  gnt;
   logic        idle;
   logic        hs;
   logic [31:0] sel_addr;
   logic        sel_d;
   logic        sel_size;
   logic        sel_fault;
   logic [31:0] cap_lo;
   logic        own_rsp_ready;

   assign idle = (state_q == IDLE);

   // The pointer only moves in IDLE, where a grant is always a handshake.
   rr_arb2 u_arb (
      .valid_i  ({d_req_valid, i_req_valid}),
      .last_i   (last_q),
      .accept_i (idle),
      .gnt_o    (gnt),
      .last_d_o (last_d)
   );

   assign i_req_ready = idle & gnt[0];
   assign d_req_ready = idle & gnt[1];
   assign hs          = idle & (|gnt);

   assign sel_d     = gnt[1];
   assign sel_addr  = sel_d ? d_req_addr : i_req_addr;
   assign sel_size  = sel_d & d_req_size;
   assign sel_fault = addr_fault(sel_addr, sel_d, sel_size, ADDR_WIDTH);

   assign cap_lo        = lane32(rom_rdata, lane_hi_q);
   assign own_rsp_ready = (own_q == OWN_D) ? d_rsp_ready : i_rsp_ready;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         own_q         <= OWN_I;
         size_q        <= SZ_W;
         lane_hi_q     <= 1'b0;
         last_q        <= 1'b1;
         rom_addr_q    <= '0;
         i_rsp_valid_q <= 1'b0;
         d_rsp_valid_q <= 1'b0;
         i_rsp_data_q  <= '0;
         d_rsp_data_q  <= '0;
         i_rsp_err_q   <= 1'b0;
         d_rsp_err_q   <= 1'b0;
      end else begin
         last_q <= last_d;
         case (state_q)
            IDLE: begin
               if (hs) begin
                  own_q     <= sel_d ? OWN_D : OWN_I;
                  size_q    <= req_size_e'(sel_size);
                  lane_hi_q <= sel_addr[2];
                  if (sel_fault) begin
                     // Fault: answer next cycle, ROM address left alone.
                     if (sel_d) begin
                        d_rsp_valid_q <= 1'b1;
                        d_rsp_err_q   <= 1'b1;
                        d_rsp_data_q  <= '0;
                     end else begin
                        i_rsp_valid_q <= 1'b1;
                        i_rsp_err_q   <= 1'b1;
                        i_rsp_data_q  <= '0;
                     end
                     state_q <= RESP;
                  end else begin
                     rom_addr_q <= sel_addr[ADDR_WIDTH+2:3];
                     state_q    <= ISSUE;
                  end
               end
            end
            ISSUE: state_q <= CAPTURE;
            CAPTURE: begin
               if (own_q == OWN_D) begin
                  d_rsp_valid_q <= 1'b1;
                  d_rsp_err_q   <= 1'b0;
                  d_rsp_data_q  <= (size_q == SZ_D) ? rom_rdata : {32'h0, cap_lo};
               end else begin
                  i_rsp_valid_q <= 1'b1;
                  i_rsp_err_q   <= 1'b0;
                  i_rsp_data_q  <= cap_lo;
               end
               state_q <= RESP;
            end
            RESP: begin
               if (own_rsp_ready) begin
                  i_rsp_valid_q <= 1'b0;
                  d_rsp_valid_q <= 1'b0;
                  state_q       <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign rom_addr    = rom_addr_q;
   assign i_rsp_valid = i_rsp_valid_q;
   assign i_rsp_data  = i_rsp_data_q;
   assign i_rsp_err   = i_rsp_err_q;
   assign d_rsp_valid = d_rsp_valid_q;
   assign d_rsp_data  = d_rsp_data_q;
   assign d_rsp_err   = d_rsp_err_q;

endmodule
